parallel_to_serial_tx: RTL and testbench
========================================

# parallel_to_serial_tx

Framed parallel-to-serial transmitter that consumes the WIDTH-bit word held by the 4-bit parallel register stage and shifts it onto a single line. It accepts a word through a valid/ready handshake and emits one frame per word: a start bit, the data LSB first, an optional even-parity bit, and a stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the downstream stage of the parallel register in the serial output path.

## Interface
- WIDTH, 4: data word width; legal range 1 to 16.
- CLKS_PER_BIT, 2: clock cycles each line bit is held; must be 1 or greater.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data; 0 omits it.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- data_in  input  WIDTH  parallel word from the register stage.
- load_valid  input  1  data_in is valid this cycle.
- load_ready  output  1  high when the block can accept a word.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress; always the inverse of load_ready.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, load_ready=1. When load_valid is high at a rising edge:
  - capture data_in into the shift register;
  - compute parity as the XOR of all data_in bits;
  - go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx equals shift register bit 0. After each CLKS_PER_BIT period:
  - shift the register right by one;
  - increment the bit index.
  - After WIDTH bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: tx equals the captured parity bit (even parity: 1 when the word has an odd count of 1s). Held for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Bit timer: counts 0 to CLKS_PER_BIT-1 and pulses bit_done on the terminal count. It clears on every state transition.
- data_in and load_valid are ignored outside IDLE. The captured word is immune to later changes on data_in.
- Bit index width: clog2(WIDTH+1). Timer width: clog2(CLKS_PER_BIT+1).

## Timing
- Reset values: tx=1, load_ready=1, busy=0, state=IDLE, shift register=0, bit index=0, timer=0, parity=0.
- Reset asserted mid-frame: tx returns to 1 asynchronously and the frame is abandoned. There is no partial-frame completion after rst_n releases.
- load_ready is a combinational decode of state==IDLE.
- Handshake completes on the edge where load_valid and load_ready are both high.
- Latency: tx falls to 0 on the first rising edge after acceptance.
- Frame length: (WIDTH + PARITY_EN + 2) × CLKS_PER_BIT cycles, counted from the first START cycle to the last STOP cycle.
- Back-to-back frames:
  - load_ready rises in the cycle after the last STOP cycle.
  - A word offered with load_valid held high is accepted on that edge.
  - The line therefore idles at 1 for exactly one cycle between frames.
- CLKS_PER_BIT=1: each bit lasts one cycle and bit_done is asserted continuously. No cycle is skipped or duplicated.
- load_valid arriving during a frame: not accepted, and load_ready stays 0 until the frame ends. The upstream stage must hold the word.

## Structure
- Shared package ptx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - a frame-length function of WIDTH, PARITY_EN and CLKS_PER_BIT, for reuse by the bench.
- One sub-module, ptx_bit_timer: parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output bit_done.
- The FSM, shift register, bit index and parity all live in the top module.

## Test plan
All scenarios use the defaults (WIDTH=4, CLKS_PER_BIT=2, PARITY_EN=1) unless stated.
- Reset: assert rst_n=0 -> tx=1, load_ready=1, busy=0. Offer load_valid while in reset -> no frame starts.
- Single frame: load 4'b0101 -> tx sequence 0,1,0,1,0,0,1 with each bit held 2 cycles. 14 cycles total; load_ready returns high on cycle 15.
- Parity: load 4'b0111 -> parity bit 1 (sequence 0,1,1,1,0,1,1). Load 4'b1111 -> parity bit 0.
- Back-to-back with load_valid held high: words 4'b0110 then 4'b1010 -> two correct frames separated by exactly one idle-high cycle. Toggling data_in mid-frame has no effect on tx.
- Reset mid-frame: drop rst_n during DATA of 4'b1010 -> tx=1 immediately. After release, a new load of 4'b0101 produces a clean full frame.
- Parameter sweep: CLKS_PER_BIT=1 and PARITY_EN=0 -> load 4'b1001 yields 0,1,0,0,1,1, one cycle per bit, 6 cycles total.

Source files
------------

// File: rtl/ptx_pkg.sv
// ptx_pkg
// Shared definitions for the framed parallel-to-serial transmitter:
//   - ptx_state_e : frame FSM states
//   - frame_len() : clocks per frame (start + data + optional parity + stop),
//                   each bit held for clks_per_bit cycles
package ptx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } ptx_state_e;

    function automatic int unsigned frame_len(input int unsigned width,
                                              input int unsigned parity_en,
                                              input int unsigned clks_per_bit);
        return (width + parity_en + 2) * clks_per_bit;
    endfunction

endpackage

// File: rtl/ptx_bit_timer.sv
// ptx_bit_timer
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the
// terminal count. A synchronous clear restarts the period.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   clear    : restart the period at count 0 on the next edge
//   bit_done : high while the counter sits on its terminal count
module ptx_bit_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // With CLKS_PER_BIT=1 the count never leaves 0, so bit_done stays high.
    assign bit_done = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear || bit_done) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/parallel_to_serial_tx.sv
// parallel_to_serial_tx
// Framed parallel-to-serial transmitter. Accepts a WIDTH-bit word through a
// valid/ready handshake and sends: start bit (0), data LSB first, optional
// even-parity bit, stop bit (1). Each line bit lasts CLKS_PER_BIT clocks.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   data_in    : parallel word from the register stage
//   load_valid : data_in is valid this cycle
//   load_ready : block can accept a word (state is IDLE)
//   tx         : serial line, idles high
//   busy       : frame in progress, inverse of load_ready
module parallel_to_serial_tx
    import ptx_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 2,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             tx,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    ptx_state_e       state_q,  state_d;
    logic [WIDTH-1:0] shift_q,  shift_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             parity_q, parity_d;
    logic             tx_q,     tx_d;

    logic bit_done;
    logic timer_clear;

    ptx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .bit_done (bit_done)
    );

    assign load_ready = (state_q == IDLE);
    assign busy       = ~load_ready;
    assign tx         = tx_q;

    // Every state change starts a fresh bit period.
    assign timer_clear = (state_d != state_q);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;

        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shift_d  = data_in;
                    parity_d = ^data_in;
                    idx_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes on the
    // same edge as the state, giving start-bit latency of one edge.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Testbench for parallel_to_serial_tx: scoreboard of expected line bits per
// busy cycle, filled when the model predicts acceptance, drained by a monitor.
module tb_parallel_to_serial_tx;
    import ptx_pkg::*;

    localparam int W   = 4;
    localparam int CPB = 2;
    localparam int PE  = 1;
    localparam int FL  = int'(frame_len(W, PE, CPB));

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready;
    logic         tx;
    logic         busy;

    logic [W-1:0] data_in2;
    logic         load_valid2;
    logic         load_ready2;
    logic         tx2;
    logic         busy2;

    always #5 clk = ~clk;

    parallel_to_serial_tx #(
        .WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(PE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .tx(tx), .busy(busy)
    );

    parallel_to_serial_tx #(
        .WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in2), .load_valid(load_valid2),
        .load_ready(load_ready2), .tx(tx2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    int rem = 0;
    bit done = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    // Frame = start 0, data LSB first, even parity, stop 1; each bit CPB clocks.
    function automatic void push_frame(input logic [W-1:0] w);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
        if (PE != 0) bits.push_back(^w);
        bits.push_back(1'b1);
        foreach (bits[i]) repeat (CPB) exp_q.push_back(bits[i]);
    endfunction

    // One driver cycle: drive at negedge, check handshake against the model.
    task automatic cycle(input logic v, input logic [W-1:0] d, output bit acc);
        @(negedge clk);
        load_valid = v;
        data_in    = d;
        chk("load_ready", load_ready, rem == 0);
        chk("busy", busy, rem != 0);
        acc = 1'b0;
        if (v && rem == 0) begin
            push_frame(d);
            rem = FL;
            acc = 1'b1;
        end else if (rem > 0) begin
            rem--;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), a);
    endtask

    // hold=1: keep load_valid high with the word until taken (back-to-back).
    // hold=0: wait with load_valid low and a toggling data_in, then offer.
    task automatic send(input logic [W-1:0] w, input bit hold);
        bit a;
        a = 1'b0;
        if (hold) begin
            for (int i = 0; i < FL + 4 && !a; i++) cycle(1'b1, w, a);
        end else begin
            while (rem != 0) cycle(1'b0, W'($urandom), a);
            cycle(1'b1, w, a);
        end
        if (!a) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    // Monitor: one expected line bit per busy cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && !done) begin
                if (busy) begin
                    if (exp_q.size() == 0) chk("tx_unexpected_frame", 1'b1, 1'b0);
                    else chk("tx", tx, exp_q.pop_front());
                end else begin
                    chk("tx_idle", tx, 1'b1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        logic [W-1:0] w;
        bit bits2[$];

        rst_n       = 1'b0;
        load_valid  = 1'b1;
        data_in     = 4'b0101;
        load_valid2 = 1'b0;
        data_in2    = '0;

        // Reset: outputs idle even with load_valid offered.
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", tx, 1'b1);
            chk("rst_ready", load_ready, 1'b1);
            chk("rst_busy", busy, 1'b0);
        end
        load_valid = 1'b0;
        #2 rst_n = 1'b1;
        idle(3);

        // Directed frames, then back-to-back with valid held.
        send(4'b0101, 1'b0);
        send(4'b0111, 1'b0);
        send(4'b1111, 1'b0);
        idle(2);
        send(4'b0110, 1'b1);
        send(4'b1010, 1'b1);
        idle(FL + 2);

        // Reset during DATA of 4'b1010.
        send(4'b1010, 1'b0);
        repeat (4) cycle(1'b0, W'($urandom), a);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_ready", load_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        exp_q.delete();
        rem = 0;
        load_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_hold_tx", tx, 1'b1);
        load_valid = 1'b0;
        #2 rst_n = 1'b1;
        idle(2);
        send(4'b0101, 1'b0);
        idle(FL + 2);

        // Randomized traffic, data_in toggling mid-frame.
        for (int n = 0; n < 40; n++) begin
            w = W'($urandom);
            send(w, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
        end
        idle(FL + 3);
        chk("scoreboard_empty", exp_q.size() == 0, 1'b1);

        // CLKS_PER_BIT=1, PARITY_EN=0 instance: 4'b1001 -> 0,1,0,0,1,1.
        w = 4'b1001;
        bits2.push_back(1'b0);
        for (int i = 0; i < 4; i++) bits2.push_back(w[i]);
        bits2.push_back(1'b1);
        @(negedge clk);
        chk("p2_ready_idle", load_ready2, 1'b1);
        load_valid2 = 1'b1;
        data_in2    = w;
        @(negedge clk);
        load_valid2 = 1'b0;
        data_in2    = 4'b0110;
        foreach (bits2[i]) begin
            chk("p2_busy", busy2, 1'b1);
            chk("p2_tx", tx2, bits2[i]);
            @(negedge clk);
        end
        chk("p2_end_busy", busy2, 1'b0);
        chk("p2_end_tx", tx2, 1'b1);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
